pimc_rcv: RTL and testbench
===========================

Name: pimc_rcv

Overview:
Per-processor receiving end of the PIMC interrupt message interface. It sits beside each core and watches the shared notify/lineno/processor_id message lines. It accepts messages addressed to its own processor ID, queues the line numbers in a small FIFO, and returns irqack to the controller. The core pops line numbers through a pending/take handshake.

Parameters:
PROC_ID, 8'h00, processor ID this receiver answers to; compared against processor_id.
QDEPTH, 4, pending-line FIFO depth; power of two, minimum 2.

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
notify  input  1  message strobe from controller; low = message valid, high = idle
lineno  input  8  IRQ line number of the message; valid while notify low
processor_id  input  8  target processor of the message; valid while notify low
irqack  output  1  one-cycle acknowledge to controller
core_ie  input  1  core interrupt enable; masks irq_pending only
irq_pending  output  1  queue non-empty and core_ie high
irq_line  output  8  line number at FIFO head; valid when irq_pending
irq_take  input  1  core pops FIFO head this cycle
q_level  output  $clog2(QDEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - irqack=0, irq_pending=0, irq_line=0, q_level=0.
  - FIFO pointers cleared; state=IDLE.
  - Reset mid-message discards the message. No ack is issued; the controller keeps notify low and the message is re-captured after release.
- FSM states: IDLE, ACK, RELEASE.
- IDLE:
  - Capture condition: notify==0, processor_id==PROC_ID, and FIFO not full, where full is computed from the registered q_level.
  - On capture: push lineno, irqack<=1, go to ACK.
  - If processor_id does not match PROC_ID: stay in IDLE with no ack. Exactly one receiver exists per ID.
  - If FIFO is full: stay in IDLE with no ack. The message stays pending at the controller (backpressure).
- ACK:
  - irqack is high for exactly this one cycle; irqack<=0 next edge; go to RELEASE.
- RELEASE:
  - Wait for notify==1, then go to IDLE.
  - A notify that stays low is never captured twice.
  - Minimum spacing between two captures: 3 cycles.
- Capture latency: notify sampled low at edge N → irqack high N+1..N+2 → entry visible on irq_line and q_level at N+1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - irq_line is driven combinationally from the head entry.
  - irq_take with q_level==0 is ignored.
- Simultaneous push and pop:
  - q_level unchanged; both pointers advance.
  - Push while full is impossible by construction. A pop in the same cycle does not enable a push; the capture waits one cycle.
- core_ie=0: irq_pending is forced low while queueing and acks continue. irq_take is still honoured.

Optional Feature:
Macro PIMC_RCV_COALESCE_EN.
- Defined:
  - Adds a 256-bit queued-line bitmap, set on push and cleared on pop.
  - A matching message whose lineno is already queued is still acknowledged normally (IDLE→ACK→RELEASE) but not pushed. Such a duplicate is accepted even when the FIFO is full.
  - Bitmap cleared on reset.
- Undefined: every accepted message is pushed; duplicate line numbers occupy separate FIFO entries.

Test Plan:
1. Reset, PROC_ID=3; notify low with lineno=5, id=3 → irqack one-cycle pulse, irq_line=5, q_level=1, irq_pending=1; controller raises notify → IDLE.
2. notify low with id=7 for 10 cycles → irqack never asserts, q_level stays 0.
3. Four messages (lines 1,2,3,4) with no take → q_level=4. A fifth message (line 9) held low is not acked. One irq_take → line 9 acked on a later cycle, and pops yield 2,3,4,9 in order.
4. notify held low for 20 cycles after ack → exactly one entry captured; release then a new message → second entry.
5. core_ie=0 with line 6 queued → irq_pending=0, irq_line=6. core_ie=1 → irq_pending=1. irq_take on empty queue → q_level stays 0.
6. Coalescing: with PIMC_RCV_COALESCE_EN, send line 8 twice → two acks, q_level=1. Without the macro → q_level=2. rst_n low mid-ACK → irqack=0 immediately, q_level=0.

Source files
------------

// File: rtl/pimc_rcv.sv
// PIMC per-core interrupt receiver: captures messages addressed to PROC_ID, queues line numbers, acks the controller.
// Optional line coalescing is enabled by defining PIMC_RCV_COALESCE_EN.
module pimc_rcv #(
  parameter logic [7:0] PROC_ID = 8'h00,
  parameter int         QDEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      notify,
  input  logic [7:0]                lineno,
  input  logic [7:0]                processor_id,
  output logic                      irqack,
  input  logic                      core_ie,
  output logic                      irq_pending,
  output logic [7:0]                irq_line,
  input  logic                      irq_take,
  output logic [$clog2(QDEPTH):0]   q_level
);

  localparam int AW = $clog2(QDEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [7:0]      r_mem [QDEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_match;
  logic            w_dup;
  logic            w_capture;
  logic            w_push;
  logic            w_pop;

  assign w_head    = r_mem[r_rptr];
  assign w_full    = (r_level == LW'(QDEPTH));
  assign w_empty   = (r_level == '0);
  assign w_match   = !notify && (processor_id == PROC_ID);
  // Fullness comes from the registered level, so a same-cycle pop never makes room for a push.
  assign w_capture = (r_state == IDLE) && w_match && (!w_full || w_dup);
  assign w_push    = w_capture && !w_dup;
  assign w_pop     = irq_take && !w_empty;

`ifdef PIMC_RCV_COALESCE_EN
  logic [255:0] r_queued;

  assign w_dup = r_queued[lineno];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_queued <= '0;
    end else begin
      if (w_pop)
        r_queued[w_head] <= 1'b0;
      if (w_push)
        r_queued[lineno] <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_stateNext = ACK;
      ACK:     w_stateNext = RELEASE;
      RELEASE: if (notify) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    irqack      = (r_state == ACK);
    irq_pending = core_ie && !w_empty;
    irq_line    = w_empty ? 8'h00 : w_head;
    q_level     = r_level;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= lineno;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (w_pop && !w_push)
        r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: tb/tb_pimc_rcv.sv
// Scoreboard bench for pimc_rcv (PROC_ID=3, QDEPTH=4); expected lines are queued at issue and checked on pop.
module tb_pimc_rcv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       notify;
  logic [7:0] lineno;
  logic [7:0] processorId;
  logic       irqack;
  logic       coreIe;
  logic       irqPending;
  logic [7:0] irqLine;
  logic       irqTake;
  logic [2:0] qLevel;

  int testCount = 0;
  int failCount = 0;
  int ackCount  = 0;
  int ackBase;
  logic [7:0] expQ [$];

  pimc_rcv #(.PROC_ID(8'h03), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .notify(notify), .lineno(lineno),
    .processor_id(processorId), .irqack(irqack), .core_ie(coreIe),
    .irq_pending(irqPending), .irq_line(irqLine), .irq_take(irqTake),
    .q_level(qLevel)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic [7:0] line, input logic [7:0] id);
    @(posedge clk);
    #2;
    notify      = n;
    lineno      = line;
    processorId = id;
  endtask

  task automatic waitAck(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (irqack) return;
    end
    testCount++;
    failCount++;
    $display("[TB] FAIL %s: irqack not seen within %0d cycles, expected pulse", name, bound);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic takeOne();
    @(posedge clk);
    #2 irqTake = 1'b1;
    @(posedge clk);
    #2 irqTake = 1'b0;
  endtask

  task automatic sendAndRelease(input logic [7:0] line, input string name);
    applyStimulus(1'b0, line, 8'h03);
    waitAck(name, 10);
    applyStimulus(1'b1, line, 8'h03);
    waitCycles(2);
  endtask

  // Monitor: checks popped head entries against the scoreboard and that every ack lasts one cycle.
  initial begin
    logic prevAck;
    prevAck = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (irqack) begin
          ackCount++;
          checkOutput("ackPulseWidth", int'(prevAck), 0);
        end
        if (irqTake && qLevel != 0) begin
          if (expQ.size() == 0) begin
            checkOutput("popUnexpected", int'(irqLine), -1);
          end else begin
            checkOutput("popLine", int'(irqLine), int'(expQ.pop_front()));
          end
        end
        prevAck = irqack;
      end else begin
        prevAck = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; notify = 1'b1; lineno = 8'h00; processorId = 8'h00;
    coreIe = 1'b1; irqTake = 1'b0;
    waitCycles(3);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetAck", int'(irqack), 0);
    checkOutput("resetPending", int'(irqPending), 0);
    checkOutput("resetLine", int'(irqLine), 0);
    checkOutput("resetLevel", int'(qLevel), 0);

    // 1: basic capture
    ackBase = ackCount;
    expQ.push_back(8'd5);
    applyStimulus(1'b0, 8'd5, 8'h03);
    waitAck("t1Ack", 10);
    checkOutput("t1Line", int'(irqLine), 5);
    checkOutput("t1Level", int'(qLevel), 1);
    checkOutput("t1Pending", int'(irqPending), 1);
    @(negedge clk);
    checkOutput("t1AckDrop", int'(irqack), 0);
    applyStimulus(1'b1, 8'd5, 8'h03);
    waitCycles(2);
    takeOne();
    @(negedge clk);
    checkOutput("t1LevelAfterPop", int'(qLevel), 0);

    // 2: foreign processor id
    ackBase = ackCount;
    applyStimulus(1'b0, 8'h11, 8'h07);
    waitCycles(10);
    checkOutput("t2NoAck", ackCount - ackBase, 0);
    checkOutput("t2Level", int'(qLevel), 0);
    applyStimulus(1'b1, 8'h11, 8'h07);

    // 3: fill, backpressure, then drain in order
    for (int i = 1; i <= 4; i++) begin
      expQ.push_back(8'(i));
      sendAndRelease(8'(i), "t3Ack");
    end
    checkOutput("t3LevelFull", int'(qLevel), 4);
    ackBase = ackCount;
    expQ.push_back(8'd9);
    applyStimulus(1'b0, 8'd9, 8'h03);
    waitCycles(6);
    checkOutput("t3NoAckFull", ackCount - ackBase, 0);
    checkOutput("t3LevelHeld", int'(qLevel), 4);
    takeOne();
    waitAck("t3AckAfterTake", 10);
    checkOutput("t3LevelRefill", int'(qLevel), 4);
    applyStimulus(1'b1, 8'd9, 8'h03);
    for (int i = 0; i < 4; i++) takeOne();
    @(negedge clk);
    checkOutput("t3LevelDrained", int'(qLevel), 0);

    // 4: notify held low is captured once
    ackBase = ackCount;
    expQ.push_back(8'h21);
    applyStimulus(1'b0, 8'h21, 8'h03);
    waitAck("t4Ack", 10);
    waitCycles(20);
    checkOutput("t4SingleAck", ackCount - ackBase, 1);
    checkOutput("t4Level", int'(qLevel), 1);
    applyStimulus(1'b1, 8'h21, 8'h03);
    waitCycles(2);
    expQ.push_back(8'h22);
    sendAndRelease(8'h22, "t4Ack2");
    checkOutput("t4Level2", int'(qLevel), 2);
    takeOne();
    takeOne();

    // 5: core interrupt enable masking and empty take
    expQ.push_back(8'd6);
    sendAndRelease(8'd6, "t5Ack");
    @(posedge clk); #2 coreIe = 1'b0;
    @(negedge clk);
    checkOutput("t5PendingMasked", int'(irqPending), 0);
    checkOutput("t5LineMasked", int'(irqLine), 6);
    @(posedge clk); #2 coreIe = 1'b1;
    @(negedge clk);
    checkOutput("t5PendingUnmasked", int'(irqPending), 1);
    takeOne();
    takeOne();
    @(negedge clk);
    checkOutput("t5EmptyTakeLevel", int'(qLevel), 0);
    checkOutput("t5EmptyPending", int'(irqPending), 0);

    // 6: duplicate line number, then reset during ACK
    ackBase = ackCount;
    expQ.push_back(8'd8);
    sendAndRelease(8'd8, "t6Ack1");
`ifndef PIMC_RCV_COALESCE_EN
    expQ.push_back(8'd8);
`endif
    sendAndRelease(8'd8, "t6Ack2");
    checkOutput("t6AckCount", ackCount - ackBase, 2);
`ifdef PIMC_RCV_COALESCE_EN
    checkOutput("t6LevelCoalesced", int'(qLevel), 1);
`else
    checkOutput("t6LevelSeparate", int'(qLevel), 2);
`endif
    applyStimulus(1'b0, 8'h30, 8'h03);
    waitAck("t6AckBeforeReset", 10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6ResetAck", int'(irqack), 0);
    checkOutput("t6ResetLevel", int'(qLevel), 0);
    expQ.delete();
    notify = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    waitCycles(2);
    checkOutput("t6LevelAfterReset", int'(qLevel), 0);
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
